// File: rtl/seg7_rx.sv
// ---------------------------------------------------------------------------
// seg7_rx
//
// Purpose:
//   Receives an asynchronous, active-low seven-segment display bus, filters
//   out transient patterns, and decodes each stable glyph once into a hex
//   nibble presented on a valid/ready output register.
//
//   seg_in -> 2-flop synchronizer -> seg_s -> stability counter -> FSM
//   (TRACK/HOLD) -> decode table -> output register (nibble/valid) with
//   overrun and error flags.
//
// Parameters:
//   STABLE_CYCLES  consecutive cycles (1..255) a synchronized pattern must
//                  hold before it is decoded.
//
// Ports:
//   clk          sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   seg_in[6:0]  active-low segments, bit0 = a .. bit6 = g (async to clk)
//   ready_in     downstream accepts nibble_out when high with valid_out
//   clr_in       synchronous clear of overrun_out
//   nibble_out   decoded value 0x0..0xF
//   valid_out    nibble_out holds a value not yet accepted
//   err_out      one-cycle pulse on a stable pattern outside the hex table
//   overrun_out  sticky: a decoded value was dropped (output register busy)
//
// Optional feature (macro SEG7_RX_DP_EN):
//   seg_dp_in    active-low decimal point, synchronized and stability-checked
//                together with seg_in as one 8-bit pattern
//   dp_out       decimal point on-state (1 = lit), loaded with nibble_out
// ---------------------------------------------------------------------------
module seg7_rx #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  input  logic       ready_in,
  input  logic       clr_in,
  output logic [3:0] nibble_out,
  output logic       valid_out,
  output logic       err_out,
  output logic       overrun_out
`ifdef SEG7_RX_DP_EN
  ,
  input  logic       seg_dp_in,
  output logic       dp_out
`endif
);

`ifdef SEG7_RX_DP_EN
  localparam int unsigned PW = 8;
`else
  localparam int unsigned PW = 7;
`endif

  // Counter value at which a pattern has been seen for STABLE_CYCLES cycles.
  localparam logic [7:0] FIRE_CNT = 8'(STABLE_CYCLES - 1);
  localparam logic [6:0] BLANK    = 7'b1111111;

  typedef enum logic {
    TRACK,
    HOLD
  } state_t;

  state_t state, state_nxt;

  logic [PW-1:0] raw;
  logic [PW-1:0] sync1;
  logic [PW-1:0] seg_s;
  logic [PW-1:0] seg_d;
  logic [7:0]    cnt;
  logic          changed;
  logic          fire;
  logic          hit;
  logic          blank;
  logic [3:0]    dec_val;
  logic          load_ok;
  logic          out_free;

`ifdef SEG7_RX_DP_EN
  assign raw = {seg_dp_in, seg_in};
`else
  assign raw = seg_in;
`endif

  // -------------------------------------------------------------------------
  // Two-flop synchronizer; resets to the all-off (blank) pattern.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      seg_s <= '1;
    end else begin
      sync1 <= raw;
      seg_s <= sync1;
    end
  end

  // -------------------------------------------------------------------------
  // Stability counter. seg_d is seg_s delayed one cycle; any difference
  // restarts the count, otherwise it counts up and saturates at 255.
  // -------------------------------------------------------------------------
  assign changed = (seg_s != seg_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_d <= '1;
      cnt   <= '0;
    end else begin
      seg_d <= seg_s;
      if (changed) begin
        cnt <= '0;
      end else if (cnt != 8'hFF) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  // A decode fires exactly once per stable pattern: only from TRACK, only
  // while the pattern is still unchanged this cycle.
  assign fire = (state == TRACK) && !changed && (cnt == FIRE_CNT);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= TRACK;
    end else begin
      state <= state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state. HOLD leaves on any change of seg_s; the counter is
  // cleared on that same edge by the changed term above.
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      TRACK: begin
        if (fire) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (changed) begin
          state_nxt = TRACK;
        end
      end
      default: state_nxt = TRACK;
    endcase
  end

  // -------------------------------------------------------------------------
  // Decode table, active-low, bit order g..a.
  // -------------------------------------------------------------------------
  always_comb begin
    hit     = 1'b1;
    dec_val = 4'h0;
    unique case (seg_s[6:0])
      7'b1000000: dec_val = 4'h0;
      7'b1111001: dec_val = 4'h1;
      7'b0100100: dec_val = 4'h2;
      7'b0110000: dec_val = 4'h3;
      7'b0011001: dec_val = 4'h4;
      7'b0010010: dec_val = 4'h5;
      7'b0000010: dec_val = 4'h6;
      7'b1111000: dec_val = 4'h7;
      7'b0000000: dec_val = 4'h8;
      7'b0010000: dec_val = 4'h9;
      7'b0001000: dec_val = 4'hA;
      7'b0000011: dec_val = 4'hB;
      7'b1000110: dec_val = 4'hC;
      7'b0100001: dec_val = 4'hD;
      7'b0000110: dec_val = 4'hE;
      7'b0001110: dec_val = 4'hF;
      default:    hit     = 1'b0;
    endcase
  end

  assign blank = (seg_s[6:0] == BLANK);

  // The output register is free when empty or being drained this cycle.
  assign out_free = !valid_out || ready_in;
  assign load_ok  = fire && hit;

  // -------------------------------------------------------------------------
  // Output register and flags
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nibble_out  <= '0;
      valid_out   <= 1'b0;
      err_out     <= 1'b0;
      overrun_out <= 1'b0;
`ifdef SEG7_RX_DP_EN
      dp_out      <= 1'b0;
`endif
    end else begin
      err_out <= fire && !hit && !blank;

      if (load_ok && out_free) begin
        nibble_out <= dec_val;
        valid_out  <= 1'b1;
`ifdef SEG7_RX_DP_EN
        dp_out     <= ~seg_s[7];
`endif
      end else if (valid_out && ready_in) begin
        valid_out <= 1'b0;
      end

      // Set has priority over clear when both happen on one edge.
      if (load_ok && !out_free) begin
        overrun_out <= 1'b1;
      end else if (clr_in) begin
        overrun_out <= 1'b0;
      end
    end
  end

endmodule

// File: doc/seg7_rx.md
SEG7_RX -- requirements
Module: seg7_rx

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, legal range 1..255: consecutive cycles a synchronized pattern must hold before it is decoded.
REQ-002 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-004 SHALL have port seg_in, input, 7: active-low segment bus, bit0 = segment a through bit6 = segment g, asynchronous to clk.
REQ-005 SHALL have port ready_in, input, 1: downstream accepts nibble_out when high with valid_out.
REQ-006 SHALL have port clr_in, input, 1: synchronous clear of overrun_out.
REQ-007 SHALL have port nibble_out, output, 4: decoded hex value 0x0..0xF.
REQ-008 SHALL have port valid_out, output, 1: nibble_out holds an unaccepted value.
REQ-009 SHALL have port err_out, output, 1: one-cycle pulse on a stable pattern not in the hex table.
REQ-010 SHALL have port overrun_out, output, 1: sticky, a decoded value was dropped.

Function
REQ-011 SHALL pass seg_in through a two-flop synchronizer; all logic below uses the synchronized value (seg_s).
REQ-012 SHALL keep an 8-bit stability counter: cleared when seg_s differs from its value one cycle earlier, else incremented, saturating at 255.
REQ-013 SHALL implement FSM states TRACK and HOLD; reset state TRACK.
REQ-014 In TRACK, when the counter reaches STABLE_CYCLES-1, SHALL decode seg_s once and enter HOLD.
REQ-015 In HOLD, SHALL emit nothing further; any change of seg_s SHALL return to TRACK with counter 0.
REQ-016 Decode table (active-low, g..a): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-017 Pattern 1111111 (blank) SHALL produce no output, no error, and enter HOLD.
REQ-018 Any other non-table pattern SHALL pulse err_out for exactly one cycle, load nothing, and enter HOLD.
REQ-019 Valid decode SHALL load nibble_out and set valid_out on the next edge if the output register is free (valid_out=0, or valid_out=1 and ready_in=1 that cycle).
REQ-020 If the output register is not free, SHALL drop the new value, keep nibble_out unchanged, and set overrun_out.
REQ-021 valid_out SHALL clear on the edge where valid_out=1 and ready_in=1 unless REQ-019 reloads it the same edge; nibble_out SHALL be stable while valid_out=1 and ready_in=0.
REQ-022 Latency: seg_in changing to a steady table pattern before edge k (output register free) SHALL give valid_out=1 after edge k+STABLE_CYCLES+2.
REQ-023 overrun_out SHALL clear on clr_in=1; if a set and clr_in coincide, set wins.
REQ-024 A pattern change before the counter reaches STABLE_CYCLES-1 SHALL discard the pattern silently (glitch rejection).

Reset
REQ-025 On rst_n=0, SHALL immediately force: synchronizer flops to 1111111, counter 0, FSM TRACK, nibble_out 0x0, valid_out 0, err_out 0, overrun_out 0.
REQ-026 Reset asserted mid-track or with valid_out pending SHALL discard all state; no output until a fresh pattern meets REQ-022 after rst_n deasserts.

Configuration
REQ-027 With macro SEG7_RX_DP_EN defined, SHALL add input seg_dp_in (active-low decimal point, synchronized and stability-checked with seg_in as an 8-bit pattern) and output dp_out, loaded alongside nibble_out with the dp on-state (1 = lit).
REQ-028 Without SEG7_RX_DP_EN, seg_dp_in and dp_out SHALL not exist and behaviour SHALL be as REQ-011..024.

Verification
REQ-029 STABLE_CYCLES=4, ready_in=1, seg_in=0100100 held -> valid_out=1, nibble_out=0x2 exactly 6 edges after change, one transfer only.
REQ-030 seg_in 0000000 held 2 cycles then 1111001 held -> no output for 0x8; 0x1 delivered once.
REQ-031 seg_in=0000001 held -> err_out high exactly one cycle, valid_out stays 0; seg_in=1111111 -> no err, no valid.
REQ-032 ready_in=0, patterns 0x3, blank, 0x7 each held 8 cycles -> nibble_out=0x3 retained, overrun_out=1; clr_in pulse -> overrun_out=0.
REQ-033 valid_out=1 with ready_in=1 on the same edge a new 0xA decodes -> nibble_out=0xA, valid_out stays 1, overrun_out=0.
REQ-034 rst_n pulsed low with valid_out=1 and counter mid-count -> all outputs 0 immediately; held pattern re-decoded after 6 edges.
